// File: rtl/unpool_upsampler.sv
// unpool_upsampler: 2x2 nearest-neighbour unpooling of a row-major pooled pixel stream.
module unpool_upsampler #(
  parameter int DATA_W = 15,
  parameter int W_IN = 8,
  parameter int H_IN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof
);
  localparam int CW = W_IN > 1 ? $clog2(W_IN) : 1;
  localparam int RW = H_IN > 1 ? $clog2(H_IN) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(W_IN - 1);
  localparam logic [RW-1:0] LAST_R = RW'(H_IN - 1);
  typedef enum logic {FILL, REPLAY} state_t;
  state_t state, state_n;
  logic [CW-1:0] col, col_n, wcol;
  logic [RW-1:0] row, row_n;
  logic dup, dup_n, vld, vld_n;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] rowbuf [W_IN];
  logic fill, last_c, last_r, xfer, acc;
  assign fill = state == FILL;
  assign last_c = col == LAST_C;
  assign last_r = row == LAST_R;
  assign out_valid = !fill | vld;
  assign out_data = fill ? data_r : rowbuf[col];
  assign xfer = out_valid & out_ready;
  // the last column of a FILL row must hand over to REPLAY before taking new input
  assign in_ready = fill & (!vld | (out_ready & dup & !last_c));
  assign acc = in_valid & in_ready;
  assign wcol = vld ? col + 1'b1 : col;
  assign out_sof = out_valid & fill & row == '0 & col == '0 & !dup;
  assign out_eol = out_valid & last_c & dup;
  assign out_eof = out_eol & !fill & last_r;
  always_comb begin
    state_n = state;
    col_n = col;
    row_n = row;
    dup_n = dup;
    vld_n = vld & !(xfer & dup);
    if (xfer) begin
      dup_n = !dup;
      if (dup) begin
        col_n = last_c ? '0 : col + 1'b1;
        state_n = last_c ? (fill ? REPLAY : FILL) : state;
        row_n = (last_c & !fill) ? (last_r ? '0 : row + 1'b1) : row;
      end
    end
    if (acc) begin
      vld_n = 1'b1;
      dup_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      col <= '0;
      row <= '0;
      dup <= 1'b0;
      vld <= 1'b0;
      data_r <= '0;
    end else begin
      state <= state_n;
      col <= col_n;
      row <= row_n;
      dup <= dup_n;
      vld <= vld_n;
      if (acc) data_r <= in_data;
    end
  end
  always_ff @(posedge clk) begin
    if (acc) rowbuf[wcol] <= in_data;
  end
endmodule
